// File: rtl/spm_driver.sv
// Operand driver and product collector for the spm serial-parallel multiplier.
// Holds x in parallel, streams sign-extended y LSB-first, and gathers the serial product.
module spm_driver #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned P_LAT = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_x,
    input  logic [WIDTH-1:0]   in_y,
    output logic [WIDTH-1:0]   spm_x,
    output logic               spm_y,
    output logic               spm_clr,
    input  logic               spm_p,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out_p
);

    localparam int unsigned PW     = 2 * WIDTH;
    localparam int unsigned NSHIFT = PW + P_LAT;
    localparam int unsigned CW     = $clog2(NSHIFT + 1);

    typedef enum logic [1:0] {StIdle, StClear, StShift, StDone} state_e;

    state_e            state_q;
    logic [WIDTH-1:0]  y_sh_q;
    logic [PW-1:0]     prod_q;
    logic [CW-1:0]     cnt_q;

    // y_sh_q resets to zero, so spm_y is zero out of reset as well.
    assign spm_y = y_sh_q[0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_p     <= '0;
            spm_x     <= '0;
            spm_clr   <= 1'b0;
            y_sh_q    <= '0;
            prod_q    <= '0;
            cnt_q     <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        spm_x    <= in_x;
                        y_sh_q   <= in_y;
                        in_ready <= 1'b0;
                        spm_clr  <= 1'b1;
                        state_q  <= StClear;
                    end
                end
                StClear: begin
                    spm_clr <= 1'b0;
                    cnt_q   <= '0;
                    state_q <= StShift;
                end
                StShift: begin
                    // Arithmetic shift keeps feeding the sign bit once y is exhausted.
                    y_sh_q <= {y_sh_q[WIDTH-1], y_sh_q[WIDTH-1:1]};
                    cnt_q  <= cnt_q + 1'b1;
                    // spm_p lags spm_y by P_LAT cycles; earlier bits are stale.
                    if (cnt_q >= CW'(P_LAT)) begin
                        prod_q <= {spm_p, prod_q[PW-1:1]};
                    end
                    if (cnt_q == CW'(NSHIFT - 1)) begin
                        out_p     <= {spm_p, prod_q[PW-1:1]};
                        out_valid <= 1'b1;
                        state_q   <= StDone;
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state_q   <= StIdle;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spm_driver.sv
// Directed bench for spm_driver with a behavioural serial-parallel multiplier model.
// Covers reset, signed products, backpressure, mid-operation reset and back-to-back flow.
module tb_spm_driver;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned P_LAT = 1;
    localparam int          LAT   = 2 * WIDTH + P_LAT + 2;

    logic              clk;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [WIDTH-1:0]  in_x;
    logic [WIDTH-1:0]  in_y;
    logic [WIDTH-1:0]  spm_x;
    logic              spm_y;
    logic              spm_clr;
    logic              spm_p;
    logic              out_valid;
    logic              out_ready;
    logic [63:0]       out_p;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    int clr_cnt  = 0;

    spm_driver #(.WIDTH(WIDTH), .P_LAT(P_LAT)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_x      (in_x),
        .in_y      (in_y),
        .spm_x     (spm_x),
        .spm_y     (spm_y),
        .spm_clr   (spm_clr),
        .spm_p     (spm_p),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_p     (out_p)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (spm_clr) clr_cnt <= clr_cnt + 1;
    end

    // Multiplier model: bit k of the running sum is final once term k is added.
    logic [63:0] m_acc;
    int          m_k;
    always @(posedge clk) begin
        if (rst || spm_clr) begin
            m_acc = '0;
            m_k   = 0;
            spm_p <= 1'b0;
        end else if (m_k < 64) begin
            if (spm_y) m_acc = m_acc + ({{32{spm_x[31]}}, spm_x} << m_k);
            spm_p <= m_acc[m_k];
            m_k   = m_k + 1;
        end else begin
            spm_p <= 1'b0;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] smul(input logic [31:0] x, input logic [31:0] y);
        logic [63:0] xs;
        logic [63:0] ys;
        xs = {{32{x[31]}}, x};
        ys = {{32{y[31]}}, y};
        return xs * ys;
    endfunction

    // Presents operands and returns just after the accepting edge.
    task automatic send(input logic [31:0] x, input logic [31:0] y, input bit hold);
        @(negedge clk);
        in_x     = x;
        in_y     = y;
        in_valid = 1'b1;
        for (int i = 0; i < 300 && !in_ready; i++) @(negedge clk);
        if (!in_ready) check("send_timeout", {63'd0, in_ready}, 64'd1);
        @(posedge clk);
        #1;
        if (!hold) in_valid = 1'b0;
    endtask

    // Waits for out_valid, checks latency and product, optionally acknowledges.
    task automatic get(input string tag, input logic [63:0] exp, input bit ack);
        int lat;
        lat = 0;
        for (int i = 0; i < 300 && !out_valid; i++) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_lat"}, 64'(lat), 64'(LAT));
        check({tag, "_p"}, out_p, exp);
        check({tag, "_inrdy"}, {63'd0, in_ready}, 64'd0);
        if (ack) begin
            out_ready = 1'b1;
            @(posedge clk);
            #1;
            out_ready = 1'b0;
        end
    endtask

    initial begin
        int          prev_cyc;
        int          clr0;
        logic [31:0] rx;
        logic [31:0] ry;
        logic [63:0] exp;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_x      = '0;
        in_y      = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_in_ready", {63'd0, in_ready}, 64'd1);
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_out_p", out_p, 64'd0);
        check("rst_spm_x", {32'd0, spm_x}, 64'd0);
        check("rst_spm_y", {63'd0, spm_y}, 64'd0);
        check("rst_spm_clr", {63'd0, spm_clr}, 64'd0);

        send(32'd3, 32'd5, 1'b0);
        get("basic", 64'd15, 1'b1);

        send(-32'sd7, 32'd6, 1'b0);
        get("neg", 64'hFFFF_FFFF_FFFF_FFD6, 1'b1);
        @(negedge clk);
        check("idle_hold_x", {32'd0, spm_x}, {32'd0, -32'sd7});
        check("idle_hold_p", out_p, 64'hFFFF_FFFF_FFFF_FFD6);

        send(32'h8000_0000, 32'h8000_0000, 1'b0);
        get("corner", 64'h4000_0000_0000_0000, 1'b1);

        // Backpressure with a second pair waiting upstream.
        send(32'd100, -32'sd2, 1'b0);
        get("bp", 64'hFFFF_FFFF_FFFF_FF38, 1'b0);
        in_x     = 32'd9;
        in_y     = -32'sd9;
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_stable_p", out_p, 64'hFFFF_FFFF_FFFF_FF38);
            check("bp_in_ready", {63'd0, in_ready}, 64'd0);
            check("bp_spm_x", {32'd0, spm_x}, 64'd100);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        check("bp_idle", {63'd0, in_ready}, 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        get("bp2", 64'hFFFF_FFFF_FFFF_FFAF, 1'b1);

        // Reset at SHIFT c=20: negedges of CLEAR, then c=0..20.
        send(32'h5555, 32'd3, 1'b0);
        repeat (22) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_in_ready", {63'd0, in_ready}, 64'd1);
        check("mid_rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("mid_rst_out_p", out_p, 64'd0);
        send(32'h1234, 32'h10, 1'b0);
        get("after_rst", 64'h12340, 1'b1);

        // Back-to-back with both handshakes held high.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_x      = $urandom;
        in_y      = $urandom;
        prev_cyc  = 0;
        for (int op = 0; op < 4; op++) begin
            for (int i = 0; i < 300 && !in_ready; i++) @(negedge clk);
            check("b2b_accept", {63'd0, in_ready}, 64'd1);
            if (op > 0) check("b2b_period", 64'(cyc - prev_cyc), 64'(LAT + 1));
            prev_cyc = cyc;
            clr0     = clr_cnt;
            exp      = smul(in_x, in_y);
            @(posedge clk);
            #1;
            rx   = $urandom;
            ry   = $urandom;
            in_x = rx;
            in_y = ry;
            for (int i = 0; i < 300 && !out_valid; i++) @(negedge clk);
            check("b2b_p", out_p, exp);
            check("b2b_clr", 64'(clr_cnt - clr0), 64'd1);
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
